// File: rtl/mmio_bus_pkg.sv
// mmio_bus_pkg
// Shared definitions for the memory-mapped peripheral bus. The initiator and
// the peripherals on the bus both import this package.
// Contents: the initiator FSM state encoding, the default bus widths, and the
// bus-cycle constants that peripherals and the initiator have to agree on.
package mmio_bus_pkg;

    localparam int MMIO_ADDR_W = 5;
    localparam int MMIO_DATA_W = 32;

    // A bus access is a single strobe cycle. Read data may be returned up to
    // MMIO_MAX_READ_LATENCY cycles after that strobe.
    localparam int MMIO_ACCESS_CYCLES    = 1;
    localparam int MMIO_MAX_READ_LATENCY = 7;
    localparam int MMIO_LAT_W            = 3;

    typedef logic [MMIO_LAT_W-1:0] mmio_lat_cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } mmio_state_e;

endpackage

// File: rtl/mmio_bus_initiator.sv
// mmio_bus_initiator
// Turns single CPU-side read/write requests into one access on the peripheral
// bus, then returns the result on a response handshake.
//
// Ports
//   clk, reset_n                  clock; asynchronous active-low reset
//   req_valid/req_ready           request handshake (req_write, req_addr, req_wdata)
//   rsp_valid/rsp_ready           response handshake (rsp_write, rsp_rdata)
//   chip_select, read_enable,
//   write_enable, address_bus,
//   write_data                    registered bus drive
//   read_data                     bus read data, combinational from the peripheral
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | req_ready=1; waiting for a request
// ST_ACCESS | single strobe cycle on the bus
// ST_WAIT   | read latency countdown; chip_select and address held
// ST_RESP   | rsp_valid=1 until rsp_ready is seen
module mmio_bus_initiator
    import mmio_bus_pkg::*;
#(
    parameter int ADDR_W       = MMIO_ADDR_W,
    parameter int DATA_W       = MMIO_DATA_W,
    parameter int READ_LATENCY = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              chip_select,
    output logic              read_enable,
    output logic              write_enable,
    output logic [ADDR_W-1:0] address_bus,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data
);

    mmio_state_e       state_q, state_d;
    mmio_lat_cnt_t     cnt_q, cnt_d;
    logic              is_write_q, is_write_d;
    logic              cs_q, cs_d;
    logic              re_q, re_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_write_q, rsp_write_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            is_write_q  <= 1'b0;
            cs_q        <= 1'b0;
            re_q        <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_write_q  <= is_write_d;
            cs_q        <= cs_d;
            re_q        <= re_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_write_d  = is_write_q;
        cs_d        = cs_q;
        re_d        = 1'b0;   // strobes are single-cycle pulses
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    cs_d       = 1'b1;
                    addr_d     = req_addr;
                    we_d       = req_write;
                    re_d       = !req_write;
                    is_write_d = req_write;
                    // Reads leave write_data untouched so the bus does not toggle.
                    if (req_write) begin
                        wdata_d = req_wdata;
                    end
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (is_write_q) begin
                    cs_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = ST_RESP;
                end else if (READ_LATENCY == 0) begin
                    cs_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = read_data;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d   = mmio_lat_cnt_t'(READ_LATENCY);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                // The final WAIT cycle is the one entered with a count of one.
                if (cnt_q == mmio_lat_cnt_t'(1)) begin
                    cs_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = read_data;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign rsp_valid    = rsp_valid_q;
    assign rsp_write    = rsp_write_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign chip_select  = cs_q;
    assign read_enable  = re_q;
    assign write_enable = we_q;
    assign address_bus  = addr_q;
    assign write_data   = wdata_q;

endmodule
